ps2_kbd_rx: RTL and testbench



---
 rtl/ps2_kbd_rx.sv | 148 ++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters PS2_CLK, then deframes 11-bit frames into scan codes.
// Optional break-code folding (0xF0 prefix -> BREAK flag) is enabled with `define PS2_BREAK_DECODE_EN.
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BREAK
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, filt_dly_q, fall_q;
  logic [7:0]    fcnt_q, fcnt_d;
  state_t        state_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q, dout_q;
  logic          par_q, dv_q, perr_q, ferr_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
`ifdef PS2_BREAK_DECODE_EN
  logic          brk_q, brk_pend_q;
`endif

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 8'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                              fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= PS2_DATA;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      filt_dly_q <= filt_q;
      fall_q     <= filt_dly_q & ~filt_q;
    end
  end

  // Abort fires on the edge where the counter would reach TIMEOUT_CYC-1 (TIMEOUT_CYC >= 2).
  assign tcnt_d = tcnt_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tcnt_q     <= '0;
`ifdef PS2_BREAK_DECODE_EN
      brk_q      <= 1'b0;
      brk_pend_q <= 1'b0;
`endif
    end else begin
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      brk_q  <= 1'b0;
`endif
      if (state_q == S_IDLE) begin
        tcnt_q <= '0;
        if (fall_q && !dat_s2_q) begin
          state_q <= S_DATA;
          bcnt_q  <= '0;
        end
      end else if (fall_q) begin
        tcnt_q <= '0;
        unique case (state_q)
          S_DATA: begin
            shreg_q <= {dat_s2_q, shreg_q[7:1]};
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          default: begin
            state_q <= S_IDLE;
            if (!dat_s2_q)                ferr_q <= 1'b1;
            else if (!(^{shreg_q, par_q})) perr_q <= 1'b1;
            else begin
`ifdef PS2_BREAK_DECODE_EN
              if (shreg_q == 8'hF0) brk_pend_q <= 1'b1;
              else begin
                dout_q     <= shreg_q;
                dv_q       <= 1'b1;
                brk_q      <= brk_pend_q;
                brk_pend_q <= 1'b0;
              end
`else
              dout_q <= shreg_q;
              dv_q   <= 1'b1;
`endif
            end
          end
        endcase
      end else if (tcnt_d == TW'(TIMEOUT_CYC - 1)) begin
        state_q <= S_IDLE;
        ferr_q  <= 1'b1;
        tcnt_q  <= '0;
      end else begin
        tcnt_q <= tcnt_d;
      end
    end
  end

  assign DATA_OUT   = dout_q;
  assign DATA_VALID = dv_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
`ifdef PS2_BREAK_DECODE_EN
  assign BREAK      = brk_q;
`else
  assign BREAK      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of frames plus hand-written timeout, glitch and reset sequences.
// Shortened PS/2 bit period and timeout keep the run small; expectations follow the macro setting.
module tb_ps2_kbd_rx;
  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int H  = 40;
`ifdef PS2_BREAK_DECODE_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  localparam int K_N = 0, K_V = 1, K_P = 2, K_F = 3;

  logic       CLK = 1'b0, RST = 1'b1, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID, PARITY_ERR, FRAME_ERR, BREAK;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR(FRAME_ERR), .BREAK(BREAK)
  );

  always #10 CLK = ~CLK;

  typedef struct { int cyc; int kind; logic [7:0] d; logic b; } ev_t;
  typedef struct { logic [7:0] d; logic par; logic stop; int kind; logic brk; } vec_t;

  ev_t  evq[$];
  int   cyc = 0, multi = 0, brk_bad = 0;
  int   checks = 0, failures = 0;
  logic [7:0] exp_dout;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (DATA_VALID || PARITY_ERR || FRAME_ERR)
        evq.push_back('{cyc, DATA_VALID ? K_V : (PARITY_ERR ? K_P : K_F), DATA_OUT, BREAK});
      if (int'(DATA_VALID) + int'(PARITY_ERR) + int'(FRAME_ERR) > 1) multi++;
      if (!BRK_EN && BREAK) brk_bad++;
    end
  end

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, output int last_fall);
    last_fall = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); PS2_DATA = bits[i];
      repeat (H) @(negedge CLK);
      PS2_CLK = 1'b0; last_fall = cyc;
      repeat (H) @(negedge CLK);
      PS2_CLK = 1'b1;
    end
    @(negedge CLK); PS2_DATA = 1'b1;
  endtask

  task automatic run_frame(input string name, input vec_t v);
    int t;
    evq.delete();
    send_bits({v.stop, v.par, v.d, 1'b0}, 11, t);
    repeat (FL + 20) @(negedge CLK);
    if (v.kind == K_N) chk({name, "_nopulse"}, evq.size(), 0);
    else begin
      chk({name, "_npulse"}, evq.size(), 1);
      if (evq.size() >= 1) begin
        chk({name, "_kind"}, evq[0].kind, v.kind);
        chk({name, "_latency"}, evq[0].cyc - t, FL + 4);
        chk({name, "_break"}, int'(evq[0].b), int'(v.brk));
      end
    end
    if (v.kind == K_V) exp_dout = v.d;
    chk({name, "_dout"}, int'(DATA_OUT), int'(exp_dout));
    repeat (20) @(negedge CLK);
  endtask

  task automatic glitch(input int n);
    @(negedge CLK); PS2_DATA = 1'b0; PS2_CLK = 1'b0;
    repeat (n) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (30) @(negedge CLK);
    PS2_DATA = 1'b1;
  endtask

  initial begin
    vec_t vt[12];
    int   t, w;
    vt[0]  = '{8'h1C, 1'b0, 1'b1, K_V, 1'b0};
    vt[1]  = '{8'h1C, 1'b1, 1'b1, K_P, 1'b0};
    vt[2]  = '{8'h29, 1'b0, 1'b0, K_F, 1'b0};
    vt[3]  = '{8'h29, 1'b0, 1'b1, K_V, 1'b0};
    vt[4]  = '{8'hF0, 1'b1, 1'b1, BRK_EN ? K_N : K_V, 1'b0};
    vt[5]  = '{8'h1C, 1'b1, 1'b1, K_P, 1'b0};
    vt[6]  = '{8'h1C, 1'b0, 1'b1, K_V, BRK_EN};
    vt[7]  = '{8'hE0, 1'b0, 1'b1, K_V, 1'b0};
    vt[8]  = '{8'h00, 1'b1, 1'b1, K_V, 1'b0};
    vt[9]  = '{8'hFF, 1'b1, 1'b1, K_V, 1'b0};
    vt[10] = '{8'h5A, 1'b0, 1'b1, K_P, 1'b0};
    vt[11] = '{8'hA5, 1'b1, 1'b1, K_V, 1'b0};

    exp_dout = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_dout", int'(DATA_OUT), 0);
    chk("rst_valid", int'(DATA_VALID), 0);
    chk("rst_perr", int'(PARITY_ERR), 0);
    chk("rst_ferr", int'(FRAME_ERR), 0);
    chk("rst_break", int'(BREAK), 0);
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    for (int i = 0; i < 12; i++) run_frame($sformatf("vec%0d", i), vt[i]);

    evq.delete();
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 4, t);
    w = 0;
    while (evq.size() == 0 && w < TO + FL + 300) begin @(negedge CLK); w++; end
    repeat (200) @(negedge CLK);
    chk("tmo_npulse", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("tmo_kind", evq[0].kind, K_F);
      chk("tmo_latency", evq[0].cyc - t, FL + 3 + TO);
    end
    chk("tmo_dout", int'(DATA_OUT), int'(exp_dout));
    run_frame("after_tmo", '{8'h5A, 1'b1, 1'b1, K_V, 1'b0});

    evq.delete();
    glitch(4);
    glitch(FL - 1);
    chk("glitch_nopulse", evq.size(), 0);
    run_frame("after_glitch", '{8'h29, 1'b0, 1'b1, K_V, 1'b0});

    evq.delete();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, t);
    @(negedge CLK); RST = 1'b1;
    #1;
    chk("midrst_dout", int'(DATA_OUT), 0);
    chk("midrst_valid", int'(DATA_VALID), 0);
    chk("midrst_perr", int'(PARITY_ERR), 0);
    chk("midrst_ferr", int'(FRAME_ERR), 0);
    exp_dout = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (TO + 100) @(negedge CLK);
    chk("midrst_nopulse", evq.size(), 0);
    chk("midrst_dout_held", int'(DATA_OUT), 0);
    run_frame("after_rst", '{8'h1C, 1'b0, 1'b1, K_V, 1'b0});

    chk("exclusive_pulses", multi, 0);
    chk("break_tied_off", brk_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
